addr_gen_upd_wu: RTL and testbench
==================================

Name: addr_gen_upd_wu

Overview:
- Address/control sequencer for the weight-update phase, run after the backprop delta stage has filled the dgate memories.
- For every weight element (cell i, input j), it reads dgate[t][i] and x[t][j] for all timesteps so the datapath MAC can accumulate the gradient sum.
- It then issues the read and write of the weight element so the datapath can write back w - lr*grad.
- One instance is used per weight matrix: W (input side) or U (recurrent side), layer 1 or layer 2.

Parameters:
- ADDR_WIDTH, 12, width of all address outputs; requires NUM_CELL*NUM_INPUT and TIMESTEP*max(NUM_CELL,NUM_INPUT) <= 2^ADDR_WIDTH.
- TIMESTEP, 7, number of timesteps accumulated per weight element.
- NUM_CELL, 8, rows of the weight matrix (cells of this layer).
- NUM_INPUT, 53, columns of the weight matrix (inputs or cells feeding this gate).
- DELAY, 3, cycles from a read address being issued to its product reaching the MAC accumulate input; must be >= 1.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- en, input, 1, start request; sampled only in IDLE.
- o_busy, output, 1, high from the cycle after start until o_done.
- o_rd_valid, output, 1, read addresses below are valid this cycle.
- o_addr_d, output, ADDR_WIDTH, dgate read address = t*NUM_CELL + i.
- o_addr_x, output, ADDR_WIDTH, x/h read address = t*NUM_INPUT + j.
- o_addr_w_rd, output, ADDR_WIDTH, weight read address = i*NUM_INPUT + j.
- o_rst_acc, output, 1, MAC load (clear-and-accumulate) for the first timestep of an element.
- o_acc, output, 1, MAC accumulate enable.
- o_wr, output, 1, weight write strobe.
- o_addr_w_wr, output, ADDR_WIDTH, weight write address.
- o_done, output, 1, one-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, all counters 0, all pipeline stages cleared.
- States: IDLE, RUN, FLUSH, DONE.
- All outputs are registered.
- IDLE:
  - At the edge where en=1, load t=i=j=0 and go to RUN.
  - The first read address is valid in the cycle after that edge.
- RUN issues one read per cycle with o_rd_valid=1, loop order t innermost, then j, then i:
  - t increments 0..TIMESTEP-1.
  - When t wraps: t=0 and j increments.
  - When j wraps at NUM_INPUT: j=0 and i increments.
- o_addr_w_rd holds i*NUM_INPUT+j for every cycle of that element, so the weight value is ready by write-back.
- Each issued read pushes {valid, first=(t==0), last=(t==TIMESTEP-1), waddr} into a shift register DELAY+1 deep.
- Pipeline outputs, counted from the read cycle:
  - o_acc = valid delayed DELAY.
  - o_rst_acc = valid&first delayed DELAY.
  - o_wr = valid&last delayed DELAY+1.
  - o_addr_w_wr = waddr delayed DELAY+1; held at its last value when o_wr=0.
- o_rst_acc and o_acc are asserted together on a first-timestep read; the datapath treats rst_acc as a load.
- TIMESTEP=1: every read is both first and last.
- After the final read (i=NUM_CELL-1, j=NUM_INPUT-1, t=TIMESTEP-1), go to FLUSH with o_rd_valid=0.
- FLUSH lasts DELAY+1 cycles, until the last o_wr is emitted.
- DONE: o_done=1 for exactly one cycle, the cycle after the last o_wr, then IDLE.
- o_busy is 1 in RUN and FLUSH, and 0 in DONE and IDLE.
- Run length from the start edge:
  - Issue cycles: N = NUM_CELL*NUM_INPUT*TIMESTEP.
  - Last o_wr at cycle N+DELAY+1.
  - o_done at cycle N+DELAY+2.
- en is ignored outside IDLE; held-high en restarts only after returning to IDLE.
- en=1 in the same cycle o_done is high: ignored, since the FSM is not yet in IDLE.
- Asynchronous rst mid-run: immediate return to IDLE; pipeline flushed, so no stray o_wr or o_acc.
- Address arithmetic is done with incrementing bases, not multipliers:
  - d base += NUM_CELL per t step, x base += NUM_INPUT per t step.
  - Both reset to 0 at each new element.
  - Results are truncated to ADDR_WIDTH.

Test Plan:
- Sequence order, with TIMESTEP=2, NUM_CELL=2, NUM_INPUT=3, DELAY=3 and a 1-cycle en pulse:
  - 12 valid cycles.
  - (d,x,w) = (0,0,0), (2,3,0), (0,1,1), (2,4,1), (0,2,2), (2,5,2), (1,0,3), (3,3,3), (1,1,4), (3,4,4), (1,2,5), (3,5,5).
- Pipeline timing, same params:
  - o_rst_acc at cycles 4,6,8,10,12,14.
  - o_acc at cycles 4..15.
  - o_wr at cycles 6,8,10,12,14,16 with o_addr_w_wr = 0..5.
  - o_done at cycle 17 only; o_busy at cycles 1..16.
- TIMESTEP=1, NUM_CELL=1, NUM_INPUT=2, DELAY=1:
  - Reads at cycles 1,2.
  - o_rst_acc=o_acc=1 at cycles 2,3.
  - o_wr at cycles 3,4 with addresses 0,1; o_done at cycle 5.
- en re-asserted at cycle 5 during a run:
  - Ignored; the output sequence is identical to the first scenario.
- rst pulsed at cycle 7 of a run:
  - All outputs 0 the same cycle.
  - No o_wr afterwards.
  - A fresh en restarts with (0,0,0).
- Default params (7,8,53,3), en held high:
  - 2968 valid cycles and 424 o_wr pulses, last at w=423.
  - o_done at cycle 2973.
  - Then a second run begins.

Source files
------------

// File: rtl/addr_gen_upd_wu.sv
// addr_gen_upd_wu: address/control sequencer for the weight-update phase.
//
// For every weight element (cell i, input j) it streams TIMESTEP reads of
// dgate[t][i] and x[t][j] so the MAC accumulates the gradient sum. A delay line
// then raises the MAC load/accumulate strobes and finally the weight write
// strobe, so the datapath can write back w - lr*grad. Loop order: t innermost,
// then j, then i.
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   en           start request, sampled only while idle
//   o_busy       high while reads are issued or the delay line drains
//   o_rd_valid   o_addr_d / o_addr_x / o_addr_w_rd valid this cycle
//   o_addr_d     dgate read address  = t*NUM_CELL  + i
//   o_addr_x     x/h read address    = t*NUM_INPUT + j
//   o_addr_w_rd  weight read address = i*NUM_INPUT + j (held for the element)
//   o_rst_acc    MAC load on the first timestep of an element
//   o_acc        MAC accumulate enable
//   o_wr         weight write strobe
//   o_addr_w_wr  weight write address, held between writes
//   o_done       one-cycle completion pulse
module addr_gen_upd_wu #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned TIMESTEP   = 7,
    parameter int unsigned NUM_CELL   = 8,
    parameter int unsigned NUM_INPUT  = 53,
    parameter int unsigned DELAY      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    output logic                  o_busy,
    output logic                  o_rd_valid,
    output logic [ADDR_WIDTH-1:0] o_addr_d,
    output logic [ADDR_WIDTH-1:0] o_addr_x,
    output logic [ADDR_WIDTH-1:0] o_addr_w_rd,
    output logic                  o_rst_acc,
    output logic                  o_acc,
    output logic                  o_wr,
    output logic [ADDR_WIDTH-1:0] o_addr_w_wr,
    output logic                  o_done
);

    localparam int unsigned TW = (TIMESTEP > 1) ? $clog2(TIMESTEP) : 1;
    localparam int unsigned IW = (NUM_CELL > 1) ? $clog2(NUM_CELL) : 1;
    localparam int unsigned JW = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
    localparam int unsigned FW = $clog2(DELAY + 1);

    localparam logic [TW-1:0] TLast = TW'(TIMESTEP - 1);
    localparam logic [IW-1:0] ILast = IW'(NUM_CELL - 1);
    localparam logic [JW-1:0] JLast = JW'(NUM_INPUT - 1);
    localparam logic [FW-1:0] FLast = FW'(DELAY);

    localparam logic [ADDR_WIDTH-1:0] DStep = ADDR_WIDTH'(NUM_CELL);
    localparam logic [ADDR_WIDTH-1:0] XStep = ADDR_WIDTH'(NUM_INPUT);
    localparam logic [ADDR_WIDTH-1:0] One   = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {StIdle, StRun, StFlush, StDone} state_e;

    state_e                  state_q;
    logic [TW-1:0]           t_q;
    logic [IW-1:0]           i_q;
    logic [JW-1:0]           j_q;
    logic [FW-1:0]           flush_q;
    logic                    busy_q;
    logic                    rd_valid_q;
    logic [ADDR_WIDTH-1:0]   addr_d_q;
    logic [ADDR_WIDTH-1:0]   addr_x_q;
    logic [ADDR_WIDTH-1:0]   addr_w_rd_q;
    logic                    wr_q;
    logic [ADDR_WIDTH-1:0]   addr_w_wr_q;
    logic                    done_q;

    // Delay line stages 0..DELAY-1; the write strobe/address form stage DELAY.
    logic [DELAY-1:0]        stg_v_q;
    logic [DELAY-1:0]        stg_f_q;
    logic [DELAY-1:0]        stg_l_q;
    logic [ADDR_WIDTH-1:0]   stg_a_q [DELAY];

    logic t_first;
    logic t_last;
    logic j_last;
    logic i_last;
    logic stg_wr;

    assign t_first = (t_q == '0);
    assign t_last  = (t_q == TLast);
    assign j_last  = (j_q == JLast);
    assign i_last  = (i_q == ILast);
    assign stg_wr  = stg_v_q[DELAY-1] & stg_l_q[DELAY-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            t_q         <= '0;
            i_q         <= '0;
            j_q         <= '0;
            flush_q     <= '0;
            busy_q      <= 1'b0;
            rd_valid_q  <= 1'b0;
            addr_d_q    <= '0;
            addr_x_q    <= '0;
            addr_w_rd_q <= '0;
            wr_q        <= 1'b0;
            addr_w_wr_q <= '0;
            done_q      <= 1'b0;
            stg_v_q     <= '0;
            stg_f_q     <= '0;
            stg_l_q     <= '0;
            for (int k = 0; k < DELAY; k++) begin
                stg_a_q[k] <= '0;
            end
        end else begin
            // Delay line: the read presented this cycle enters stage 0.
            stg_v_q[0] <= rd_valid_q;
            stg_f_q[0] <= rd_valid_q & t_first;
            stg_l_q[0] <= rd_valid_q & t_last;
            stg_a_q[0] <= addr_w_rd_q;
            for (int k = DELAY - 1; k > 0; k--) begin
                stg_v_q[k] <= stg_v_q[k-1];
                stg_f_q[k] <= stg_f_q[k-1];
                stg_l_q[k] <= stg_l_q[k-1];
                stg_a_q[k] <= stg_a_q[k-1];
            end
            wr_q <= stg_wr;
            if (stg_wr) begin
                addr_w_wr_q <= stg_a_q[DELAY-1];
            end

            unique case (state_q)
                StIdle: begin
                    if (en) begin
                        state_q     <= StRun;
                        busy_q      <= 1'b1;
                        rd_valid_q  <= 1'b1;
                        t_q         <= '0;
                        i_q         <= '0;
                        j_q         <= '0;
                        addr_d_q    <= '0;
                        addr_x_q    <= '0;
                        addr_w_rd_q <= '0;
                    end
                end
                StRun: begin
                    if (t_last && j_last && i_last) begin
                        state_q    <= StFlush;
                        rd_valid_q <= 1'b0;
                        flush_q    <= '0;
                    end else if (t_last) begin
                        // New element: bases restart at t=0, weight address steps by one.
                        t_q         <= '0;
                        addr_w_rd_q <= addr_w_rd_q + One;
                        if (j_last) begin
                            j_q      <= '0;
                            i_q      <= i_q + IW'(1);
                            addr_d_q <= ADDR_WIDTH'(i_q) + One;
                            addr_x_q <= '0;
                        end else begin
                            j_q      <= j_q + JW'(1);
                            addr_d_q <= ADDR_WIDTH'(i_q);
                            addr_x_q <= ADDR_WIDTH'(j_q) + One;
                        end
                    end else begin
                        t_q      <= t_q + TW'(1);
                        addr_d_q <= addr_d_q + DStep;
                        addr_x_q <= addr_x_q + XStep;
                    end
                end
                StFlush: begin
                    // Drain DELAY+1 cycles so the final write leaves the delay line.
                    if (flush_q == FLast) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        flush_q <= flush_q + FW'(1);
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_busy      = busy_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_addr_d    = addr_d_q;
    assign o_addr_x    = addr_x_q;
    assign o_addr_w_rd = addr_w_rd_q;
    assign o_rst_acc   = stg_f_q[DELAY-1];
    assign o_acc       = stg_v_q[DELAY-1];
    assign o_wr        = wr_q;
    assign o_addr_w_wr = addr_w_wr_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_addr_gen_upd_wu.sv
// Directed bench for addr_gen_upd_wu. Three instances share clock and reset:
//   a: TIMESTEP=2 NUM_CELL=2 NUM_INPUT=3  DELAY=3
//   b: TIMESTEP=1 NUM_CELL=1 NUM_INPUT=2  DELAY=1
//   g: default parameters (7, 8, 53, 3)
// Cycle c counts from the start edge (c=1 is the first cycle after it);
// outputs are sampled on the falling edge.
module tb_addr_gen_upd_wu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total  = 0;
    int passed = 0;

    logic        en_a, en_b, en_g;
    logic        a_busy, a_v, a_ra, a_acc, a_wr, a_done;
    logic [11:0] a_d, a_x, a_wrd, a_wwr;
    logic        b_busy, b_v, b_ra, b_acc, b_wr, b_done;
    logic [11:0] b_d, b_x, b_wrd, b_wwr;
    logic        g_busy, g_v, g_ra, g_acc, g_wr, g_done;
    logic [11:0] g_d, g_x, g_wrd, g_wwr;

    addr_gen_upd_wu #(
        .ADDR_WIDTH(12), .TIMESTEP(2), .NUM_CELL(2), .NUM_INPUT(3), .DELAY(3)
    ) u_a (
        .clk(clk), .rst(rst), .en(en_a), .o_busy(a_busy), .o_rd_valid(a_v),
        .o_addr_d(a_d), .o_addr_x(a_x), .o_addr_w_rd(a_wrd), .o_rst_acc(a_ra),
        .o_acc(a_acc), .o_wr(a_wr), .o_addr_w_wr(a_wwr), .o_done(a_done)
    );

    addr_gen_upd_wu #(
        .ADDR_WIDTH(12), .TIMESTEP(1), .NUM_CELL(1), .NUM_INPUT(2), .DELAY(1)
    ) u_b (
        .clk(clk), .rst(rst), .en(en_b), .o_busy(b_busy), .o_rd_valid(b_v),
        .o_addr_d(b_d), .o_addr_x(b_x), .o_addr_w_rd(b_wrd), .o_rst_acc(b_ra),
        .o_acc(b_acc), .o_wr(b_wr), .o_addr_w_wr(b_wwr), .o_done(b_done)
    );

    addr_gen_upd_wu u_g (
        .clk(clk), .rst(rst), .en(en_g), .o_busy(g_busy), .o_rd_valid(g_v),
        .o_addr_d(g_d), .o_addr_x(g_x), .o_addr_w_rd(g_wrd), .o_rst_acc(g_ra),
        .o_acc(g_acc), .o_wr(g_wr), .o_addr_w_wr(g_wwr), .o_done(g_done)
    );

    task automatic chk(input string tag, input int c, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s (cycle %0d): observed %0h expected %0h", tag, c, obs, exp);
    endtask

    // Hand-computed read sequence for instance a.
    int exp_d [12] = '{0, 2, 0, 2, 0, 2, 1, 3, 1, 3, 1, 3};
    int exp_x [12] = '{0, 3, 1, 4, 2, 5, 0, 3, 1, 4, 2, 5};
    int exp_w [12] = '{0, 0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};

    // One full run of instance a. en_mid re-asserts en during cycle 5 and in
    // the o_done cycle; both must be ignored.
    task automatic run_a(input bit en_mid);
        logic [5:0] ctl_exp;
        int         wa;
        en_a = 1'b1;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            ctl_exp = {(c >= 1 && c <= 16), (c <= 12),
                       (c inside {4, 6, 8, 10, 12, 14}), (c >= 4 && c <= 15),
                       (c inside {6, 8, 10, 12, 14, 16}), (c == 17)};
            chk("a_ctl{busy,v,rst_acc,acc,wr,done}", c,
                {26'd0, a_busy, a_v, a_ra, a_acc, a_wr, a_done}, {26'd0, ctl_exp});
            if (c <= 12) begin
                chk("a_addr_d", c, {20'd0, a_d}, exp_d[c-1]);
                chk("a_addr_x", c, {20'd0, a_x}, exp_x[c-1]);
                chk("a_addr_w_rd", c, {20'd0, a_wrd}, exp_w[c-1]);
            end
            if (c >= 6) begin
                wa = (c - 6) / 2;
                if (wa > 5) wa = 5;
                chk("a_addr_w_wr", c, {20'd0, a_wwr}, wa);
            end
            en_a = en_mid && (c == 5 || c == 17);
        end
        en_a = 1'b0;
    endtask

    initial begin
        int nvalid, nwr, lastw, ndone, first_done;
        logic [3:0] bctl;

        en_a = 1'b0;
        en_b = 1'b0;
        en_g = 1'b0;

        // Reset state.
        #1;
        chk("rst_a_outs", 0, {a_busy, a_v, a_ra, a_acc, a_wr, a_done, a_d, a_x}, 32'd0);
        chk("rst_a_waddr", 0, {a_wrd, a_wwr}, 32'd0);
        chk("rst_b_outs", 0, {b_busy, b_v, b_ra, b_acc, b_wr, b_done, b_wrd}, 32'd0);
        chk("rst_g_outs", 0, {g_busy, g_v, g_ra, g_acc, g_wr, g_done, g_wwr}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Plain run, then the same run with en pulsed mid-run and at o_done.
        run_a(1'b0);
        run_a(1'b1);

        // TIMESTEP=1 instance: every read is both first and last.
        en_b = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            en_b = 1'b0;
            chk("b_busy_v_done", c, {29'd0, b_busy, b_v, b_done},
                {29'd0, (c <= 4), (c <= 2), (c == 5)});
            bctl = {b_ra, b_acc, b_wr, 1'b0};
            chk("b_rst_acc_acc_wr", c, {28'd0, bctl},
                {28'd0, (c == 2 || c == 3), (c == 2 || c == 3), (c == 3 || c == 4), 1'b0});
            if (c <= 2) begin
                chk("b_addr_x", c, {20'd0, b_x}, c - 1);
                chk("b_addr_w_rd", c, {20'd0, b_wrd}, c - 1);
                chk("b_addr_d", c, {20'd0, b_d}, 0);
            end
            if (c == 3 || c == 4) chk("b_addr_w_wr", c, {20'd0, b_wwr}, c - 3);
        end

        // Default parameters with en held high.
        nvalid = 0;
        nwr = 0;
        lastw = -1;
        ndone = 0;
        first_done = 0;
        en_g = 1'b1;
        for (int c = 1; c <= 2980; c++) begin
            @(negedge clk);
            if (first_done == 0) begin
                if (g_v) nvalid++;
                if (g_wr) begin
                    nwr++;
                    lastw = int'(g_wwr);
                end
            end
            if (g_done) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
            if (c == 2) chk("g_second_read", c, {g_v, 7'd0, g_d, g_x}, {1'b1, 7'd0, 12'd8, 12'd53});
            if (c == 2968) begin
                chk("g_last_read_d", c, {20'd0, g_d}, 55);
                chk("g_last_read_x", c, {20'd0, g_x}, 370);
                chk("g_last_read_w", c, {20'd0, g_wrd}, 423);
            end
            if (c == 2969) chk("g_flush_v", c, {31'd0, g_v}, 0);
            if (c == 2972) chk("g_busy_end", c, {30'd0, g_busy, g_done}, {30'd0, 2'b10});
            if (c == 2973) chk("g_busy_done", c, {30'd0, g_busy, g_done}, {30'd0, 2'b01});
            if (c == 2975) begin
                chk("g_restart_v", c, {30'd0, g_busy, g_v}, {30'd0, 2'b11});
                chk("g_restart_addr", c, {g_d, g_x, 8'd0}, 32'd0);
                chk("g_restart_w", c, {20'd0, g_wrd}, 0);
            end
        end
        en_g = 1'b0;
        chk("g_valid_count", 0, nvalid, 2968);
        chk("g_wr_count", 0, nwr, 424);
        chk("g_last_waddr", 0, lastw, 423);
        chk("g_done_cycle", 0, first_done, 2973);
        chk("g_done_pulses", 0, ndone, 1);

        // Mid-run reset on instance a (g is also reset, harmlessly).
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        en_a = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            en_a = 1'b0;
        end
        chk("a_before_rst", 7, {30'd0, a_busy, a_v}, {30'd0, 2'b11});
        rst = 1'b1;
        #1;
        chk("a_rst_ctl", 7, {26'd0, a_busy, a_v, a_ra, a_acc, a_wr, a_done}, 32'd0);
        chk("a_rst_addr", 7, {a_d, a_x, 8'd0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("a_after_rst_quiet", c, {28'd0, a_busy, a_v, a_acc, a_wr}, 32'd0);
        end
        en_a = 1'b1;
        @(negedge clk);
        en_a = 1'b0;
        chk("a_fresh_start_v", 1, {30'd0, a_busy, a_v}, {30'd0, 2'b11});
        chk("a_fresh_start_addr", 1, {a_d, a_x, 8'd0}, 32'd0);
        chk("a_fresh_start_w", 1, {20'd0, a_wrd}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
